// File: rtl/aes_dec_ctrl.sv
// rtl/aes_dec_ctrl.sv - AES decryption round sequencer with optional round-key cache
// Optional feature: define AES_DEC_KEY_CACHE_EN to skip key expansion when the stored round keys are still valid.
module aes_dec_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       new_key,
  input  logic       abort,
  input  logic       out_ready,
  output logic       ready,
  output logic       data_load,
  output logic       key_exp_en,
  output logic       key_wr_en,
  output logic [3:0] key_idx,
  output logic       inv_shift_en,
  output logic       inv_sub_en,
  output logic       add_key_en,
  output logic       inv_mix_en,
  output logic       out_valid
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEYEXP = 3'd1,
    S_INIT   = 3'd2,
    S_ROUND  = 3'd3,
    S_FINAL  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [3:0] LP_NR    = 4'(NR);
  localparam logic [3:0] LP_NR_M1 = 4'(NR - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_hit;

`ifdef AES_DEC_KEY_CACHE_EN
  logic r_key_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_valid <= 1'b0;
    end else if (abort || new_key) begin
      r_key_valid <= 1'b0;
    end else if (r_state == S_KEYEXP && r_cnt == LP_NR) begin
      r_key_valid <= 1'b1;
    end
  end

  // A key change in the same cycle as start must force a fresh expansion.
  assign w_hit = r_key_valid & ~new_key;
`else
  logic w_unused_new_key;
  assign w_unused_new_key = new_key;
  assign w_hit            = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    ready        = 1'b0;
    data_load    = 1'b0;
    key_exp_en   = 1'b0;
    key_wr_en    = 1'b0;
    key_idx      = 4'd0;
    inv_shift_en = 1'b0;
    inv_sub_en   = 1'b0;
    add_key_en   = 1'b0;
    inv_mix_en   = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready     = 1'b1;
        w_cnt_nxt = 4'd0;
        if (start) begin
          data_load   = 1'b1;
          w_state_nxt = w_hit ? S_INIT : S_KEYEXP;
        end
      end
      S_KEYEXP: begin
        key_exp_en = 1'b1;
        key_wr_en  = 1'b1;
        key_idx    = r_cnt;
        if (r_cnt == LP_NR) begin
          w_state_nxt = S_INIT;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_INIT: begin
        add_key_en  = 1'b1;
        key_idx     = LP_NR;
        w_state_nxt = S_ROUND;
        w_cnt_nxt   = LP_NR_M1;
      end
      S_ROUND: begin
        inv_shift_en = 1'b1;
        inv_sub_en   = 1'b1;
        add_key_en   = 1'b1;
        inv_mix_en   = 1'b1;
        key_idx      = r_cnt;
        w_cnt_nxt    = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_FINAL;
        end
      end
      S_FINAL: begin
        inv_shift_en = 1'b1;
        inv_sub_en   = 1'b1;
        add_key_en   = 1'b1;
        w_state_nxt  = S_DONE;
        w_cnt_nxt    = 4'd0;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
    // Cancel wins over everything, including a start seen in IDLE.
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 4'd0;
      data_load   = 1'b0;
    end
  end

endmodule
